design_dut: RTL and testbench

- Single-clock instruction FIFO feeding a small 8-op integer ALU.
- A producer pushes 32-bit instruction words of the form {opcode, operand A, operand B, spare}.
- A consumer pops them; each pop executes the instruction and presents a registered 28-bit result with a one-cycle valid strobe.
- Sits between the processor-side command path and the slave datapath.

---
 rtl/design_dut.sv | 88 ++++++++
 tb/tb_design_dut.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/design_dut.sv
// design_dut: instruction FIFO feeding an 8-op ALU with a registered result and a one-cycle valid strobe.
// Define SIGNED_OPS_EN to treat A/B as 14-bit two's complement and to use signed SLT/SGT.
module design_dut #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic        p_clk,
   input  logic        rst,
   input  logic [31:0] data_in,
   input  logic        w_req,
   input  logic        r_req,
   output logic [27:0] data_out,
   output logic        valid,
   output logic        full,
   output logic        empty
);
   logic [31:1] r_mem [DEPTH];
   logic [AW:0] r_wr_ptr, r_rd_ptr, w_wr_nxt, w_rd_nxt;
   logic        r_full, r_empty, r_valid;
   logic [27:0] r_data;
   logic        w_do_wr, w_do_rd, w_unused;
   logic [31:1] w_word;
   logic [2:0]  w_op;
   logic [27:0] w_a, w_b, w_res;
   logic        w_lt, w_gt;

   assign w_unused = data_in[0];
   assign w_do_wr  = w_req & ~r_full;
   assign w_do_rd  = r_req & ~r_empty;
   assign w_wr_nxt = r_wr_ptr + {{AW{1'b0}}, w_do_wr};
   assign w_rd_nxt = r_rd_ptr + {{AW{1'b0}}, w_do_rd};
   assign w_word   = r_mem[r_rd_ptr[AW-1:0]];
   assign w_op     = w_word[31:29];

`ifdef SIGNED_OPS_EN
   assign w_a  = {{14{w_word[28]}}, w_word[28:15]};
   assign w_b  = {{14{w_word[14]}}, w_word[14:1]};
   assign w_lt = $signed(w_a) < $signed(w_b);
   assign w_gt = $signed(w_a) > $signed(w_b);
`else
   assign w_a  = {14'd0, w_word[28:15]};
   assign w_b  = {14'd0, w_word[14:1]};
   assign w_lt = w_a < w_b;
   assign w_gt = w_a > w_b;
`endif

   // ALU: low 28 bits of the product are exact for both 14x14 unsigned and sign-extended operands
   always_comb begin
      w_res = 28'd0;
      case (w_op)
         3'd0:    w_res = w_a + w_b;
         3'd1:    w_res = w_a - w_b;
         3'd2:    w_res = w_a & w_b;
         3'd3:    w_res = w_a | w_b;
         3'd4:    w_res = w_a * w_b;
         3'd5:    w_res = {27'd0, w_lt};
         3'd6:    w_res = {27'd0, w_gt};
         default: w_res = w_a ^ w_b;
      endcase
   end

   // Storage needs no reset; the spare bit is never stored
   always_ff @(posedge p_clk)
      if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= data_in[31:1];

   // Pointers, flags and the registered result update together
   always_ff @(posedge p_clk or negedge rst)
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_valid  <= 1'b0;
         r_data   <= 28'd0;
      end else begin
         r_wr_ptr <= w_wr_nxt;
         r_rd_ptr <= w_rd_nxt;
         r_empty  <= w_wr_nxt == w_rd_nxt;
         r_full   <= (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]) && (w_wr_nxt[AW] != w_rd_nxt[AW]);
         r_valid  <= w_do_rd;
         if (w_do_rd) r_data <= w_res;
      end

   assign data_out = r_data;
   assign valid    = r_valid;
   assign full     = r_full;
   assign empty    = r_empty;
endmodule

// File: tb/tb_design_dut.sv
// tb_design_dut: table vectors, directed corners and random traffic against a queue-based reference.
module tb_design_dut;
   localparam int DEPTH = 16;
   logic        p_clk = 1'b0, rst = 1'b0, w_req = 1'b0, r_req = 1'b0;
   logic [31:0] data_in = '0;
   logic [27:0] data_out;
   logic        valid, full, empty;
   int          n_cmp = 0, n_err = 0;
   logic [31:0] q[$];
   logic [27:0] exp_data = '0;
   logic        exp_valid = 1'b0;

   typedef struct {
      bit          w;
      bit          r;
      logic [31:0] d;
      bit          ev;
      logic [27:0] ed;
      bit          ef;
      bit          ee;
   } vec_t;
   vec_t tbl[17];

   design_dut dut (
      .p_clk(p_clk), .rst(rst), .data_in(data_in), .w_req(w_req), .r_req(r_req),
      .data_out(data_out), .valid(valid), .full(full), .empty(empty)
   );

   always #5 p_clk = ~p_clk;

   function automatic logic [31:0] mk(int op, int a, int b, int sp);
      logic [31:0] w;
      w = {op[2:0], a[13:0], b[13:0], sp[0]};
      return w;
   endfunction

   function automatic logic [27:0] ref_alu(logic [31:0] wd);
      longint a, b, r;
      a = longint'(wd[28:15]);
      b = longint'(wd[14:1]);
`ifdef SIGNED_OPS_EN
      if (a >= 8192) a = a - 16384;
      if (b >= 8192) b = b - 16384;
`endif
      case (wd[31:29])
         3'd0: r = a + b;
         3'd1: r = a - b;
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a * b;
         3'd5: r = (a < b) ? 1 : 0;
         3'd6: r = (a > b) ? 1 : 0;
         default: r = a ^ b;
      endcase
      return r[27:0];
   endfunction

   task automatic check(string name, logic [27:0] act, logic [27:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(bit w, bit r, logic [31:0] d);
      int s;
      w_req = w; r_req = r; data_in = d;
      @(posedge p_clk);
      s = q.size();
      exp_valid = 1'b0;
      if (r && s > 0) begin
         exp_data  = ref_alu(q.pop_front());
         exp_valid = 1'b1;
      end
      if (w && s < DEPTH) q.push_back(d);
      #1;
      check("valid", {27'd0, valid}, {27'd0, exp_valid});
      check("data_out", data_out, exp_data);
      check("full", {27'd0, full}, {27'd0, q.size() == DEPTH});
      check("empty", {27'd0, empty}, {27'd0, q.size() == 0});
   endtask

   initial begin
      logic [27:0] vals[8];
      vals = '{28'd16, 28'd4, 28'd1, 28'd13, 28'd45, 28'd0, 28'd1, 28'd12};
      tbl[0] = '{1'b1, 1'b0, mk(0, 8, 8, 0), 1'b0, 28'd0, 1'b0, 1'b0};
      for (int i = 1; i < 8; i++) tbl[i] = '{1'b1, 1'b0, mk(i, 9, 5, i & 1), 1'b0, 28'd0, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) tbl[8+i] = '{1'b0, 1'b1, 32'd0, 1'b1, vals[i], 1'b0, i == 7};
      tbl[16] = '{1'b0, 1'b0, 32'd0, 1'b0, 28'd12, 1'b0, 1'b1};

      repeat (2) @(posedge p_clk);
      #1;
      check("rst_valid", {27'd0, valid}, 28'd0);
      check("rst_data", data_out, 28'd0);
      check("rst_full", {27'd0, full}, 28'd0);
      check("rst_empty", {27'd0, empty}, 28'd1);
      rst = 1'b1;

      for (int i = 0; i < 17; i++) begin
         step(tbl[i].w, tbl[i].r, tbl[i].d);
         check("tbl_valid", {27'd0, valid}, {27'd0, tbl[i].ev});
         check("tbl_data", data_out, tbl[i].ed);
         check("tbl_full", {27'd0, full}, {27'd0, tbl[i].ef});
         check("tbl_empty", {27'd0, empty}, {27'd0, tbl[i].ee});
      end

      repeat (2) step(0, 1, 32'd0);
      check("empty_read_hold", data_out, 28'd12);

      for (int i = 0; i < 17; i++) begin
         step(1, 0, $urandom);
         if (i == 15) check("full_after_16", {27'd0, full}, 28'd1);
      end
      for (int i = 0; i < 17; i++) step(0, 1, 32'd0);
      check("drained_empty", {27'd0, empty}, 28'd1);

      step(1, 0, mk(1, 5, 9, 0));
      step(0, 1, 32'd0);
      check("sub_boundary", data_out, 28'd268435452);
      step(1, 0, mk(4, 16383, 16383, 1));
      step(0, 1, 32'd0);
`ifdef SIGNED_OPS_EN
      check("mul_boundary", data_out, 28'd1);
`else
      check("mul_boundary", data_out, 28'd268402689);
`endif

      step(1, 0, mk(0, 1000, 234, 0));
      step(1, 1, mk(7, 255, 15, 0));
      check("simul_data", data_out, 28'd1234);
      check("simul_occupancy", {27'd0, empty}, 28'd0);
      step(0, 1, 32'd0);
      check("simul_second", data_out, 28'd240);

      for (int i = 0; i < 40; i++) step(1, i > 0, $urandom);
      step(0, 1, 32'd0);

      for (int i = 0; i < 400; i++) step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom);

      for (int i = 0; i < 20; i++) step(0, 1, 32'd0);
      for (int i = 0; i < 5; i++) step(1, 0, $urandom);
      w_req = 1'b0; r_req = 1'b0;
      rst = 1'b0;
      #1;
      q.delete();
      exp_data = '0;
      exp_valid = 1'b0;
      check("midrst_empty", {27'd0, empty}, 28'd1);
      check("midrst_full", {27'd0, full}, 28'd0);
      check("midrst_valid", {27'd0, valid}, 28'd0);
      check("midrst_data", data_out, 28'd0);
      #2 rst = 1'b1;
      step(1, 0, mk(0, 100, 23, 1));
      step(0, 1, 32'd0);
      check("post_rst_roundtrip", data_out, 28'd123);
      step(0, 0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
